seven_segment_counter_mux: RTL and testbench

Parametrised multi-digit BCD up/down counter with a time-multiplexed seven-segment display driver. It is the next generation of the single-digit seconds counter. It adds N digits with ripple carry/borrow, count direction, run/pause, synchronous clear, lap-hold of the displayed value, and a one-hot digit scanner so that one 7-bit segment bus drives all digits. It sits between the board clock and the display pins, and exposes tick/wrap pulses for chaining or debug.

---
 rtl/seven_segment_counter_mux.sv | 105 ++++++++++
 tb/tb_seven_segment_counter_mux.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_counter_mux.sv
// rtl/seven_segment_counter_mux.sv - multi-digit BCD up/down counter with multiplexed seven-segment driver
module seven_segment_counter_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_COUNT = 1000,
    parameter int MUX_COUNT  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  down,
    input  logic                  clear,
    input  logic                  hold,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  tick,
    output logic                  wrap
);
    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int MW = (MUX_COUNT > 1) ? $clog2(MUX_COUNT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0] presc;
    logic [MW-1:0] mux_presc;
    logic [IW-1:0] idx;
    logic [3:0]    count      [NUM_DIGITS];
    logic [3:0]    snap       [NUM_DIGITS];
    logic [3:0]    count_next [NUM_DIGITS];
    logic          step;
    logic          ripple;

    // Carry/borrow ripples from digit 0 upward; surviving past the top digit means full-range wrap.
    always_comb begin
        step   = run && (presc == PW'(TICK_COUNT - 1));
        ripple = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            count_next[i] = count[i];
            if (ripple) begin
                if (down) begin
                    count_next[i] = (count[i] == 4'd0) ? 4'd9 : count[i] - 4'd1;
                    ripple        = (count[i] == 4'd0);
                end else begin
                    count_next[i] = (count[i] == 4'd9) ? 4'd0 : count[i] + 4'd1;
                    ripple        = (count[i] == 4'd9);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc     <= '0;
            mux_presc <= '0;
            idx       <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                count[i] <= 4'd0;
                snap[i]  <= 4'd0;
            end
        end else begin
            if (mux_presc == MW'(MUX_COUNT - 1)) begin
                mux_presc <= '0;
                idx       <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                mux_presc <= mux_presc + 1'b1;
            end

            if (!hold) begin
                for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= count[i];
            end

            if (clear) begin
                presc <= '0;
                tick  <= 1'b0;
                wrap  <= 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) count[i] <= 4'd0;
            end else begin
                tick <= step;
                wrap <= step && ripple;
                if (run) presc <= step ? '0 : presc + 1'b1;
                if (step) begin
                    for (int i = 0; i < NUM_DIGITS; i++) count[i] <= count_next[i];
                end
            end
        end
    end

    assign digit_sel = NUM_DIGITS'(1) << idx;

    always_comb begin
        unique case (snap[idx])
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end
endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// tb/tb_seven_segment_counter_mux.sv - randomized check of two counter configurations against an arithmetic model
module tb_seven_segment_counter_mux;
    logic clk = 1'b0;
    logic reset, run, down, clear, hold;
    logic [6:0] seg_a, seg_b;
    logic [3:0] sel_a;
    logic [1:0] sel_b;
    logic tick_a, wrap_a, tick_b, wrap_b;

    int checks = 0;
    int errors = 0;

    int nd [2] = '{4, 2};
    int tc [2] = '{4, 1};
    int mc [2] = '{2, 3};
    int presc [2];
    int count [2];
    int snap  [2];
    int scyc  [2];
    bit mtick [2];
    bit mwrap [2];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    seven_segment_counter_mux #(.NUM_DIGITS(4), .TICK_COUNT(4), .MUX_COUNT(2)) dut_a (
        .clk(clk), .reset(reset), .run(run), .down(down), .clear(clear), .hold(hold),
        .segments(seg_a), .digit_sel(sel_a), .tick(tick_a), .wrap(wrap_a)
    );

    seven_segment_counter_mux #(.NUM_DIGITS(2), .TICK_COUNT(1), .MUX_COUNT(3)) dut_b (
        .clk(clk), .reset(reset), .run(run), .down(down), .clear(clear), .hold(hold),
        .segments(seg_b), .digit_sel(sel_b), .tick(tick_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_edge(input int k);
        int lim;
        lim = pow10(nd[k]);
        if (reset) begin
            presc[k] = 0; count[k] = 0; snap[k] = 0; scyc[k] = 0;
            mtick[k] = 0; mwrap[k] = 0;
        end else begin
            if (!hold) snap[k] = count[k];
            scyc[k]++;
            if (clear) begin
                presc[k] = 0; count[k] = 0; mtick[k] = 0; mwrap[k] = 0;
            end else if (run && presc[k] == tc[k] - 1) begin
                presc[k] = 0;
                mtick[k] = 1;
                if (down) begin
                    mwrap[k] = (count[k] == 0);
                    count[k] = (count[k] + lim - 1) % lim;
                end else begin
                    mwrap[k] = (count[k] == lim - 1);
                    count[k] = (count[k] + 1) % lim;
                end
            end else begin
                if (run) presc[k]++;
                mtick[k] = 0;
                mwrap[k] = 0;
            end
        end
    endtask

    function automatic int exp_idx(input int k);
        return (scyc[k] / mc[k]) % nd[k];
    endfunction

    function automatic logic [6:0] exp_seg(input int k);
        return seg_tab[(snap[k] / pow10(exp_idx(k))) % 10];
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("a_sel",  32'(sel_a),  32'(1) << exp_idx(0));
        check("a_seg",  32'(seg_a),  32'(exp_seg(0)));
        check("a_tick", 32'(tick_a), 32'(mtick[0]));
        check("a_wrap", 32'(wrap_a), 32'(mwrap[0]));
        check("b_sel",  32'(sel_b),  32'(1) << exp_idx(1));
        check("b_seg",  32'(seg_b),  32'(exp_seg(1)));
        check("b_tick", 32'(tick_b), 32'(mtick[1]));
        check("b_wrap", 32'(wrap_b), 32'(mwrap[1]));
    endtask

    initial begin
        logic [6:0] want;
        reset = 1'b1; run = 1'b1; down = 1'b0; clear = 1'b0; hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            presc[k] = 0; count[k] = 0; snap[k] = 0; scyc[k] = 0; mtick[k] = 0; mwrap[k] = 0;
        end
        cycle();
        cycle();
        check("rst_sel", 32'(sel_a), 32'h1);
        check("rst_seg", 32'(seg_a), 32'h3F);
        check("rst_tick", 32'(tick_a), 32'h0);
        check("rst_wrap", 32'(wrap_a), 32'h0);

        // twelve steps of the 4-digit counter, then freeze and scan the display
        reset = 1'b0;
        for (int i = 0; i < 48; i++) cycle();
        run = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) begin
            cycle();
            case (sel_a)
                4'b0001: want = 7'h5B;
                4'b0010: want = 7'h06;
                default: want = 7'h3F;
            endcase
            check("scan12", 32'(seg_a), 32'(want));
        end

        // counting down from zero wraps to 9999 on the first step
        clear = 1'b1;
        cycle();
        clear = 1'b0; down = 1'b1; run = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("wrap_dn_tick", 32'(tick_a), 32'h1);
        check("wrap_dn_wrap", 32'(wrap_a), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(999) == 0);
            clear = ($urandom_range(99) == 0);
            run   = ($urandom_range(99) < 85);
            if ($urandom_range(49) == 0) down = ~down;
            if ($urandom_range(19) == 0) hold = ~hold;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
